// File: rtl/display_refresh_hold.sv
// display_refresh_hold
//
// Holds a multi-channel snapshot for a slow display consumer. Incoming
// per-channel samples are latched whenever they are qualified. Those latched
// values are copied to the display outputs on one of three events: a
// periodic tick, a tick that sees changed data, or an explicit forced
// update. The copy is then held under a request/acknowledge handshake.
// Ticks that would have produced a snapshot while a request is still
// pending are counted as overruns.
//
// Parameters
//   DW      data width per channel in bits
//   CH      number of independent channels (1..8)
//   PERIOD  tick terminal count; a tick occurs every PERIOD+1 cycles
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   data_in       CH*DW input samples, channel c at [c*DW +: DW]
//   in_valid      per-channel qualifier for data_in
//   mode          00 periodic, 01 on-change, 10/11 freeze
//   force_update  single-cycle request for an immediate snapshot
//   upd_ack       consumer acknowledge of upd_req
//   data_out      held snapshot, same packing as data_in
//   upd_req       high while a snapshot awaits acknowledge
//   ch_valid      per-channel "captured at least once since reset"
//   overrun_cnt   saturating count of ticks dropped while upd_req pending
module display_refresh_hold #(
    parameter int unsigned DW     = 32,
    parameter int unsigned CH     = 2,
    parameter int unsigned PERIOD = 24_999_999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CH*DW-1:0] data_in,
    input  logic [CH-1:0]    in_valid,
    input  logic [1:0]       mode,
    input  logic             force_update,
    input  logic             upd_ack,
    output logic [CH*DW-1:0] data_out,
    output logic             upd_req,
    output logic [CH-1:0]    ch_valid,
    output logic [7:0]       overrun_cnt
);

    localparam logic [31:0] TERM = 32'(PERIOD);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t             state;
    logic [31:0]        cnt;
    logic [CH*DW-1:0]   lat;
    logic [CH-1:0]      seen;

    logic               tick;
    logic               differs;
    logic               tick_evt;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // A tick only matters when the current mode would turn it into a
    // snapshot; the same qualification decides whether it counts as an
    // overrun while a request is pending.
    always_comb begin
        tick     = (cnt == TERM);
        differs  = (lat != data_out);
        tick_evt = tick && ((mode == 2'b00) || ((mode == 2'b01) && differs));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 32'd0;
            lat         <= '0;
            seen        <= '0;
            data_out    <= '0;
            ch_valid    <= '0;
            upd_req     <= 1'b0;
            overrun_cnt <= 8'd0;
        end else begin
            // Latches update on the same edge a snapshot is taken, so a
            // snapshot always sees the values from before this edge.
            for (int c = 0; c < CH; c++) begin
                if (in_valid[c]) begin
                    lat[c*DW +: DW] <= data_in[c*DW +: DW];
                    seen[c]         <= 1'b1;
                end
            end

            // A forced update that is accepted re-phases the tick so the
            // next periodic refresh is a full period away.
            if ((state == IDLE) && force_update) begin
                cnt <= 32'd0;
            end else if (tick) begin
                cnt <= 32'd0;
            end else begin
                cnt <= cnt + 32'd1;
            end

            if (state == IDLE) begin
                if (force_update || tick_evt) begin
                    data_out <= lat;
                    ch_valid <= seen;
                    upd_req  <= 1'b1;
                    state    <= REQ;
                end
            end else begin
                // force_update is intentionally ignored while pending.
                if (tick_evt) begin
                    overrun_cnt <= sat_inc(overrun_cnt);
                end
                if (upd_ack) begin
                    upd_req <= 1'b0;
                    state   <= IDLE;
                end
            end
        end
    end

endmodule

// File: doc/display_refresh_hold.md
DISPLAY_REFRESH_HOLD -- requirements
Module: display_refresh_hold

Interface
REQ-001 SHALL have parameter DW, default 32, meaning data width per channel in bits.
REQ-002 SHALL have parameter CH, default 2, meaning number of independent channels (1..8).
REQ-003 SHALL have parameter PERIOD, default 24_999_999, meaning tick terminal count, so a tick occurs every PERIOD+1 cycles (0.5 s at 50 MHz); legal range 1..2^32-1.
REQ-004 clk  input  1  system clock, all logic on rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 data_in  input  CH*DW  channel c occupies bits [c*DW +: DW].
REQ-007 in_valid  input  CH  bit c high qualifies data_in channel c for this cycle.
REQ-008 mode  input  2  00 periodic, 01 on-change, 10 freeze, 11 treated as freeze.
REQ-009 force_update  input  1  single-cycle request for an immediate snapshot.
REQ-010 upd_ack  input  1  display consumer acknowledge of upd_req.
REQ-011 data_out  output  CH*DW  held snapshot, same channel packing as data_in.
REQ-012 upd_req  output  1  high while a new snapshot awaits acknowledge.
REQ-013 ch_valid  output  CH  bit c high once channel c has been captured in a snapshot after reset.
REQ-014 overrun_cnt  output  8  count of ticks dropped because upd_req was pending, saturating.

Function
REQ-015 Free-running counter SHALL count 0..PERIOD, wrap to 0, assert internal tick on the cycle it equals PERIOD, in every mode and state.
REQ-016 Per-channel latch lat[c] SHALL load data_in channel c on any cycle in_valid[c]=1; seen[c] SHALL set on that edge.
REQ-017 Snapshot SHALL use lat/seen register values before the current edge; data with in_valid on the snapshot cycle is excluded.
REQ-018 FSM SHALL have two states: IDLE (upd_req=0) and REQ (upd_req=1).
REQ-019 IDLE->REQ on a snapshot event: data_out<=lat, ch_valid<=seen, upd_req<=1, all on the same edge.
REQ-020 Snapshot event SHALL be: force_update=1; or tick with mode=00; or tick with mode=01 and lat differs from data_out in any channel.
REQ-021 mode 10/11 SHALL generate no tick-based snapshot; force_update still snapshots.
REQ-022 force_update accepted in IDLE SHALL also clear the counter to 0 on the same edge.
REQ-023 REQ->IDLE on the edge where upd_ack=1; upd_req low the cycle after ack is sampled.
REQ-024 data_out and ch_valid SHALL remain stable throughout REQ.
REQ-025 upd_ack in IDLE SHALL be ignored.
REQ-026 Tick in REQ that would have produced a snapshot SHALL increment overrun_cnt, saturating at 255; force_update in REQ SHALL be ignored and not counted.
REQ-027 upd_ack and a snapshot event on the same cycle in REQ: return to IDLE, event dropped (counted per REQ-026 if tick).
REQ-028 Latency: snapshot event at cycle n -> data_out/upd_req valid at cycle n+1.

Reset
REQ-029 While rst=1 at an edge: counter=0, all lat=0, seen=0, data_out=0, ch_valid=0, upd_req=0, overrun_cnt=0, FSM=IDLE; reset dominates all inputs.
REQ-030 Reset asserted while in REQ SHALL drop the pending request without an ack.

Verification (PERIOD=9, CH=2, DW=8)
REQ-031 mode=00, ch0 in_valid with 0x5A at cycle 3, ack 2 cycles after each req -> upd_req rises at cycle 10 with data_out ch0=0x5A, ch_valid=01, and again at cycle 20.
REQ-032 mode=01, data unchanged after first snapshot -> no upd_req at cycles 20, 30; change ch1 to 0x33 at cycle 25 -> upd_req at cycle 30 with ch1=0x33.
REQ-033 mode=10, force_update at cycle 4 -> upd_req at cycle 5, counter restarts, no tick-based snapshot afterward.
REQ-034 mode=00, upd_ack never asserted for 300 ticks -> data_out frozen, overrun_cnt saturates at 255.
REQ-035 in_valid ch0 0x11 on exactly the tick cycle -> snapshot carries prior value; 0x11 appears at the next tick.
REQ-036 rst pulsed during REQ -> next cycle all outputs 0, IDLE, first tick 10 cycles after reset release.
